bp_cce_alu_issue: RTL and testbench



---
 rtl/bp_cce_alu_issue_if.sv | 59 +++++
 rtl/bp_cce_alu_issue.sv | 144 ++++++++++++++
 tb/tb_bp_cce_alu_issue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_cce_alu_issue_if.sv
// Issue and result streams between CCE decode, this sequencer and the
// result consumer. The op field is a plain vector sized by op_width_p so the
// interface does not depend on the op enumeration declared below it.
interface bp_cce_alu_issue_if #(
    parameter int width_p    = 16,
    parameter int num_gpr_p  = 8,
    parameter int op_width_p = 4,
    localparam int lg_num_gpr_lp = $clog2(num_gpr_p)
);
    // micro-op issue (ready-valid)
    logic                     inst_v_i;
    logic                     inst_ready_and_o;
    logic [op_width_p-1:0]    inst_op_i;
    logic [lg_num_gpr_lp-1:0] inst_src_a_i;
    logic [lg_num_gpr_lp-1:0] inst_src_b_i;
    logic                     inst_imm_v_i;
    logic [width_p-1:0]       inst_imm_i;
    logic [lg_num_gpr_lp-1:0] inst_dst_i;

    // result stream (ready-then-valid, consumer yumi)
    logic                     res_v_o;
    logic [width_p-1:0]       res_o;
    logic                     res_zero_o;
    logic [lg_num_gpr_lp-1:0] res_dst_o;
    logic                     res_yumi_i;

    // decode / consumer side
    modport master (
        output inst_v_i, inst_op_i, inst_src_a_i, inst_src_b_i,
               inst_imm_v_i, inst_imm_i, inst_dst_i, res_yumi_i,
        input  inst_ready_and_o, res_v_o, res_o, res_zero_o, res_dst_o
    );

    // sequencer side
    modport slave (
        input  inst_v_i, inst_op_i, inst_src_a_i, inst_src_b_i,
               inst_imm_v_i, inst_imm_i, inst_dst_i, res_yumi_i,
        output inst_ready_and_o, res_v_o, res_o, res_zero_o, res_dst_o
    );
endinterface

// CCE ALU operation encoding shared with the ALU.
package bp_cce_alu_issue_pkg;
    typedef enum logic [3:0] {
        e_alu_add  = 4'd0,
        e_alu_sub  = 4'd1,
        e_alu_lsh  = 4'd2,
        e_alu_rsh  = 4'd3,
        e_alu_and  = 4'd4,
        e_alu_or   = 4'd5,
        e_alu_xor  = 4'd6,
        e_alu_neg  = 4'd7,
        e_alu_not  = 4'd8,
        e_alu_nand = 4'd9,
        e_alu_nor  = 4'd10,
        e_alu_inc  = 4'd11,
        e_alu_dec  = 4'd12
    } bp_cce_inst_alu_op_e;
endpackage

// File: rtl/bp_cce_alu_issue.sv
// Issue/write-back sequencer for the CCE ALU: clears the GPR file after
// reset, accepts one micro-op at a time, drives the external combinational
// ALU for one cycle, holds the result until the consumer takes it and then
// writes it back to the destination GPR.
module bp_cce_alu_issue
    import bp_cce_alu_issue_pkg::*;
#(
    parameter int width_p   = 16,
    parameter int num_gpr_p = 8,
    localparam int lg_num_gpr_lp = $clog2(num_gpr_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_cce_alu_issue_if.slave        io,
    output logic [width_p-1:0]       alu_opd_a_o,
    output logic [width_p-1:0]       alu_opd_b_o,
    output bp_cce_inst_alu_op_e      alu_op_o,
    input  logic [width_p-1:0]       alu_res_i,
    input  logic                     gpr_w_v_i,
    input  logic [lg_num_gpr_lp-1:0] gpr_w_addr_i,
    input  logic [width_p-1:0]       gpr_w_data_i
);

    localparam logic [1:0] e_clear = 2'd0;
    localparam logic [1:0] e_ready = 2'd1;
    localparam logic [1:0] e_exec  = 2'd2;
    localparam logic [1:0] e_wb    = 2'd3;

    localparam logic [lg_num_gpr_lp-1:0] LAST_GPR = lg_num_gpr_lp'(num_gpr_p - 1);

    logic [1:0]               r_state;
    logic [lg_num_gpr_lp-1:0] r_cnt;
    logic [width_p-1:0]       r_gpr [num_gpr_p];

    bp_cce_inst_alu_op_e      r_op;
    logic [lg_num_gpr_lp-1:0] r_dst;
    logic [width_p-1:0]       r_opd_a;
    logic [width_p-1:0]       r_opd_b;

    logic                     r_res_v;
    logic [width_p-1:0]       r_res;
    logic [lg_num_gpr_lp-1:0] r_res_dst;

    logic                     w_accept;
    logic                     w_wb_we;
    logic                     w_ext_we;
    logic [width_p-1:0]       w_opd_a;
    logic [width_p-1:0]       w_opd_b;

    // Ready is masked by reset so nothing is taken while the block is held.
    assign io.inst_ready_and_o = (r_state == e_ready) & ~reset_i;
    assign w_accept = io.inst_v_i & io.inst_ready_and_o;
    assign w_wb_we  = (r_state == e_wb) & io.res_yumi_i & ~reset_i;
    assign w_ext_we = gpr_w_v_i & (r_state != e_clear) & ~reset_i;

    // Operand read with write-through bypass of a same-cycle external write.
    // Write-back never coincides with accept, so only the external port needs
    // bypassing here.
    assign w_opd_a = (w_ext_we && gpr_w_addr_i == io.inst_src_a_i)
                   ? gpr_w_data_i : r_gpr[io.inst_src_a_i];
    assign w_opd_b = io.inst_imm_v_i ? io.inst_imm_i
                   : (w_ext_we && gpr_w_addr_i == io.inst_src_b_i)
                   ? gpr_w_data_i : r_gpr[io.inst_src_b_i];

    // ALU drive comes straight from the latched operands, so it holds its
    // value whenever no new op is being accepted.
    assign alu_opd_a_o = r_opd_a;
    assign alu_opd_b_o = r_opd_b;
    assign alu_op_o    = r_op;

    assign io.res_v_o    = r_res_v;
    assign io.res_o      = r_res;
    assign io.res_zero_o = (r_res == '0);
    assign io.res_dst_o  = r_res_dst;

    // Sequencer: clear sweep, then ready -> exec -> wb -> ready per op.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_clear;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                e_clear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_GPR) r_state <= e_ready;
                end
                e_ready: if (w_accept) r_state <= e_exec;
                e_exec:  r_state <= e_wb;
                e_wb:    if (io.res_yumi_i) r_state <= e_ready;
                default: r_state <= e_clear;
            endcase
        end
    end

    // Latch op, destination and operands at accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_op    <= e_alu_add;
            r_dst   <= '0;
            r_opd_a <= '0;
            r_opd_b <= '0;
        end else if (w_accept) begin
            r_op    <= bp_cce_inst_alu_op_e'(io.inst_op_i);
            r_dst   <= io.inst_dst_i;
            r_opd_a <= w_opd_a;
            r_opd_b <= w_opd_b;
        end
    end

    // Capture the ALU result in exec; drop valid once the consumer takes it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_res_v   <= 1'b0;
            r_res     <= '0;
            r_res_dst <= '0;
        end else if (r_state == e_exec) begin
            r_res_v   <= 1'b1;
            r_res     <= alu_res_i;
            r_res_dst <= r_dst;
        end else if (w_wb_we) begin
            r_res_v   <= 1'b0;
        end
    end

    // GPR file: clear sweep, then write-back, then external write (lowest).
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_gpr_p; i++) begin
            if (!reset_i) begin
                if (r_state == e_clear && r_cnt == lg_num_gpr_lp'(i))
                    r_gpr[i] <= '0;
                else if (w_wb_we && r_res_dst == lg_num_gpr_lp'(i))
                    r_gpr[i] <= r_res;
                else if (w_ext_we && gpr_w_addr_i == lg_num_gpr_lp'(i))
                    r_gpr[i] <= gpr_w_data_i;
            end
        end
    end

    // A consumer must not take a result that is not being offered.
    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(io.res_yumi_i && !io.res_v_o));
    end

endmodule

// File: tb/tb_bp_cce_alu_issue.sv
// Directed bench for bp_cce_alu_issue with a behavioural ALU and a
// scoreboard of expected results.
module tb_bp_cce_alu_issue;
    import bp_cce_alu_issue_pkg::*;

    localparam int W = 16;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_cce_alu_issue_if #(.width_p(W), .num_gpr_p(N),
                          .op_width_p($bits(bp_cce_inst_alu_op_e))) bus ();

    logic [W-1:0]        opd_a, opd_b, alu_res;
    bp_cce_inst_alu_op_e alu_op;
    logic                gw_v;
    logic [2:0]          gw_a;
    logic [W-1:0]        gw_d;

    bp_cce_alu_issue #(.width_p(W), .num_gpr_p(N)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .io           (bus),
        .alu_opd_a_o  (opd_a),
        .alu_opd_b_o  (opd_b),
        .alu_op_o     (alu_op),
        .alu_res_i    (alu_res),
        .gpr_w_v_i    (gw_v),
        .gpr_w_addr_i (gw_a),
        .gpr_w_data_i (gw_d)
    );

    // behavioural ALU
    always_comb begin
        alu_res = opd_a + opd_b;
        case (alu_op)
            e_alu_sub: alu_res = opd_a - opd_b;
            e_alu_and: alu_res = opd_a & opd_b;
            e_alu_or:  alu_res = opd_a | opd_b;
            e_alu_xor: alu_res = opd_a ^ opd_b;
            default:   alu_res = opd_a + opd_b;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   dst;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        gw_v = 1'b1; gw_a = a; gw_d = d;
        @(negedge clk);
        gw_v = 1'b0;
    endtask

    // After reset release: 8 cycles of not-ready, then ready.
    task automatic wait_clear();
        for (int i = 0; i < N; i++) begin
            #1;
            chk("clear_ready", bus.inst_ready_and_o, 0);
            chk("clear_res_v", bus.res_v_o, 0);
            @(negedge clk);
        end
        #1;
        chk("clear_done_ready", bus.inst_ready_and_o, 1);
    endtask

    // One full op: accept, exec, result (with optional backpressure), yumi.
    // byp_*: external write presented in the accept cycle.
    // coll_*: external write to the destination presented in the yumi cycle.
    task automatic do_op(input bp_cce_inst_alu_op_e op, input logic [2:0] sa,
                         input logic [2:0] sbr, input logic immv, input logic [W-1:0] imm,
                         input logic [2:0] dst, input logic [W-1:0] exp_res, input int hold,
                         input logic byp_v, input logic [2:0] byp_a, input logic [W-1:0] byp_d,
                         input logic coll_v, input logic [W-1:0] coll_d);
        exp_t e, got;
        @(negedge clk);
        chk("accept_ready", bus.inst_ready_and_o, 1);
        bus.inst_v_i = 1'b1;       bus.inst_op_i = op;
        bus.inst_src_a_i = sa;     bus.inst_src_b_i = sbr;
        bus.inst_imm_v_i = immv;   bus.inst_imm_i = imm;
        bus.inst_dst_i = dst;
        if (byp_v) begin gw_v = 1'b1; gw_a = byp_a; gw_d = byp_d; end
        e.res = exp_res; e.dst = dst;
        sb.push_back(e);
        @(negedge clk);
        bus.inst_v_i = 1'b0; gw_v = 1'b0;
        chk("exec_res_v", bus.res_v_o, 0);
        chk("exec_ready", bus.inst_ready_and_o, 0);
        chk("exec_alu_op", alu_op, op);
        if (immv) chk("exec_alu_b", opd_b, imm);
        @(negedge clk);
        chk("res_v", bus.res_v_o, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            got = sb.pop_front();
            chk("res", bus.res_o, got.res);
            chk("res_dst", bus.res_dst_o, got.dst);
            chk("res_zero", bus.res_zero_o, (got.res == '0));
            for (int h = 0; h < hold; h++) begin
                if (h == 1) bus.inst_v_i = 1'b1;
                chk("hold_ready", bus.inst_ready_and_o, 0);
                @(negedge clk);
                bus.inst_v_i = 1'b0;
                chk("hold_res", bus.res_o, got.res);
                chk("hold_res_v", bus.res_v_o, 1);
            end
        end
        bus.res_yumi_i = 1'b1;
        if (coll_v) begin gw_v = 1'b1; gw_a = dst; gw_d = coll_d; end
        @(negedge clk);
        bus.res_yumi_i = 1'b0; gw_v = 1'b0;
        chk("post_res_v", bus.res_v_o, 0);
        chk("post_ready", bus.inst_ready_and_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.inst_v_i = 1'b0; bus.inst_op_i = e_alu_add;
        bus.inst_src_a_i = '0; bus.inst_src_b_i = '0;
        bus.inst_imm_v_i = 1'b0; bus.inst_imm_i = '0; bus.inst_dst_i = '0;
        bus.res_yumi_i = 1'b0;
        gw_v = 1'b0; gw_a = '0; gw_d = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready", bus.inst_ready_and_o, 0);
        chk("rst_res_v", bus.res_v_o, 0);
        chk("rst_res", bus.res_o, 0);
        chk("rst_zero", bus.res_zero_o, 1);
        chk("rst_dst", bus.res_dst_o, 0);
        chk("rst_opd_a", opd_a, 0);
        chk("rst_opd_b", opd_b, 0);
        chk("rst_alu_op", alu_op, e_alu_add);
        rst = 1'b0;
        wait_clear();

        // every GPR reads zero after the clear sweep
        for (int g = 0; g < N; g++)
            do_op(e_alu_add, 3'(g), 3'd0, 1'b1, 16'h0000, 3'(g), 16'h0000, 0, 1'b0, 3'd0, '0, 1'b0, '0);

        // 5 + 3 -> GPR2, then read it back
        ext_write(3'd1, 16'h0005);
        do_op(e_alu_add, 3'd1, 3'd0, 1'b1, 16'h0003, 3'd2, 16'h0008, 0, 1'b0, 3'd0, '0, 1'b0, '0);
        do_op(e_alu_add, 3'd2, 3'd0, 1'b1, 16'h0000, 3'd6, 16'h0008, 0, 1'b0, 3'd0, '0, 1'b0, '0);

        // wrap to zero, then confirm GPR3 == 0 via a register-register op
        ext_write(3'd3, 16'hFFFF);
        do_op(e_alu_add, 3'd3, 3'd0, 1'b1, 16'h0001, 3'd3, 16'h0000, 0, 1'b0, 3'd0, '0, 1'b0, '0);
        do_op(e_alu_or,  3'd3, 3'd1, 1'b0, 16'h0000, 3'd7, 16'h0005, 0, 1'b0, 3'd0, '0, 1'b0, '0);
        do_op(e_alu_sub, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd0, 16'hFFFD, 0, 1'b0, 3'd0, '0, 1'b0, '0);

        // backpressure with a stray inst_v pulse
        do_op(e_alu_xor, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd6, 16'h000D, 5, 1'b0, 3'd0, '0, 1'b0, '0);

        // write-back beats a same-cycle external write to the same GPR
        do_op(e_alu_add, 3'd1, 3'd0, 1'b1, 16'h0010, 3'd4, 16'h0015, 0, 1'b0, 3'd0, '0, 1'b1, 16'h1234);
        do_op(e_alu_and, 3'd4, 3'd0, 1'b0, 16'h0000, 3'd7, 16'h0015, 0, 1'b0, 3'd0, '0, 1'b0, '0);

        // write-through bypass on operand A and on operand B
        do_op(e_alu_add, 3'd6, 3'd0, 1'b1, 16'h0001, 3'd1, 16'h0101, 0, 1'b1, 3'd6, 16'h0100, 1'b0, '0);
        do_op(e_alu_sub, 3'd0, 3'd2, 1'b0, 16'h0000, 3'd2, 16'hFFFB, 0, 1'b1, 3'd2, 16'h0002, 1'b0, '0);

        // reset during exec aborts the op; GPR5 ends up cleared
        ext_write(3'd5, 16'h0777);
        @(negedge clk);
        chk("abort_accept_ready", bus.inst_ready_and_o, 1);
        bus.inst_v_i = 1'b1; bus.inst_op_i = e_alu_add;
        bus.inst_src_a_i = 3'd5; bus.inst_imm_v_i = 1'b1; bus.inst_imm_i = 16'h0001;
        bus.inst_dst_i = 3'd5;
        @(negedge clk);
        bus.inst_v_i = 1'b0;
        rst = 1'b1;
        chk("abort_exec_res_v", bus.res_v_o, 0);
        @(negedge clk);
        chk("abort_rst_res_v", bus.res_v_o, 0);
        rst = 1'b0;
        wait_clear();
        do_op(e_alu_add, 3'd5, 3'd0, 1'b1, 16'h0000, 3'd5, 16'h0000, 0, 1'b0, 3'd0, '0, 1'b0, '0);
        do_op(e_alu_or,  3'd1, 3'd4, 1'b0, 16'h0000, 3'd3, 16'h0000, 0, 1'b0, 3'd0, '0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
